// File: rtl/edge_pkg.sv
// Shared edge-detection mode encodings and default sizing for multi_edge_detector.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_DB_W        = 4;

endpackage

// File: rtl/edge_channel.sv
// One channel: synchroniser, debounce counter, mode-qualified edge pulse and sticky flag.
module edge_channel
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DB_W        = DEF_DB_W
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            data,
    input  logic [1:0]      mode,
    input  logic [DB_W-1:0] db_limit,
    input  logic            clear,
    output logic            edge_next,
    output logic            edge_detect,
    output logic            edge_sticky,
    output logic            level
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic [DB_W-1:0]        cnt;
    logic                   sync;
    logic                   change;
    logic                   rise_en;
    logic                   fall_en;

    assign sync = sync_chain[SYNC_STAGES-1];

    always_comb begin
        rise_en   = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
        fall_en   = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
        change    = (sync != level) && (cnt >= db_limit);
        edge_next = change && ((sync && rise_en) || (!sync && fall_en));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_chain  <= '0;
            cnt         <= '0;
            level       <= 1'b0;
            edge_detect <= 1'b0;
            edge_sticky <= 1'b0;
        end else begin
            sync_chain  <= {sync_chain[SYNC_STAGES-2:0], data};
            edge_detect <= edge_next;
            // set takes priority over a simultaneous clear
            edge_sticky <= (edge_sticky & ~clear) | edge_next;
            if (sync == level) begin
                cnt <= '0;
            end else if (change) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector: WIDTH independent channels plus a registered any_edge.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DB_W        = DEF_DB_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   data,
    input  logic [2*WIDTH-1:0] mode,
    input  logic [DB_W-1:0]    db_limit,
    input  logic [WIDTH-1:0]   clear,
    output logic [WIDTH-1:0]   edge_detect,
    output logic [WIDTH-1:0]   edge_sticky,
    output logic [WIDTH-1:0]   level,
    output logic               any_edge
);

    logic [WIDTH-1:0] edge_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_W        (DB_W)
        ) u_ch (
            .clock       (clock),
            .reset_n     (reset_n),
            .data        (data[i]),
            .mode        (mode[2*i +: 2]),
            .db_limit    (db_limit),
            .clear       (clear[i]),
            .edge_next   (edge_next[i]),
            .edge_detect (edge_detect[i]),
            .edge_sticky (edge_sticky[i]),
            .level       (level[i])
        );
    end

    // registered from the pre-flop pulses so it lines up with edge_detect
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            any_edge <= 1'b0;
        end else begin
            any_edge <= |edge_next;
        end
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench: run-length behavioural model plus directed literal checks and random stimulus.
module tb_multi_edge_detector;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned DB_W  = 4;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [WIDTH-1:0]   data = '0;
    logic [2*WIDTH-1:0] mode = '0;
    logic [DB_W-1:0]    db_limit = '0;
    logic [WIDTH-1:0]   clear = '0;
    logic [WIDTH-1:0]   ed;
    logic [WIDTH-1:0]   es;
    logic [WIDTH-1:0]   lv;
    logic               ae;

    int checks = 0;
    int passed = 0;

    multi_edge_detector #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC),
        .DB_W        (DB_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data        (data),
        .mode        (mode),
        .db_limit    (db_limit),
        .clear       (clear),
        .edge_detect (ed),
        .edge_sticky (es),
        .level       (lv),
        .any_edge    (ae)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Model: the debounce sees the input delayed by SYNC samples; the level flips once the
    // synchronised input has disagreed with it for more than db_limit consecutive edges.
    logic [WIDTH-1:0] dq[$];
    int unsigned      run[WIDTH];
    logic [WIDTH-1:0] m_level, m_det, m_sticky, s, nd;
    logic             m_any;
    logic [1:0]       md;
    bit               m_valid = 0;

    initial forever begin
        @(posedge clock);
        if (!reset_n) begin
            dq = {};
            for (int k = 0; k < int'(SYNC); k++) dq.push_back('0);
            for (int k = 0; k < int'(WIDTH); k++) run[k] = 0;
            m_level = '0; m_det = '0; m_sticky = '0; m_any = 1'b0;
            m_valid = 1;
        end else if (m_valid) begin
            s = dq.pop_front();
            dq.push_back(data);
            nd = '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (s[i] != m_level[i]) begin
                    if (run[i] >= int'(db_limit)) begin
                        m_level[i] = s[i];
                        run[i] = 0;
                        md = mode[2*i +: 2];
                        nd[i] = s[i] ? md[0] : md[1];
                    end else begin
                        run[i]++;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_sticky = (m_sticky & ~clear) | nd;
            m_det = nd;
            m_any = |nd;
        end
    end

    initial forever begin
        @(negedge clock);
        if (m_valid) begin
            check("model_edge_detect", 32'(ed), 32'(m_det));
            check("model_edge_sticky", 32'(es), 32'(m_sticky));
            check("model_level",       32'(lv), 32'(m_level));
            check("model_any_edge",    32'(ae), 32'(m_any));
        end
    end

    initial begin
        // reset with all inputs high, then rise pulses on every channel at edge 3
        data = 4'hF; mode = 8'hFF; db_limit = 0; reset_n = 1'b0;
        tick(3);
        check("rst_edge", 32'(ed), 0); check("rst_sticky", 32'(es), 0);
        check("rst_level", 32'(lv), 0); check("rst_any", 32'(ae), 0);
        reset_n = 1'b1;
        tick(2); check("rel_edge2", 32'(ed), 0);
        tick(1); check("rel_edge3", 32'(ed), 32'hF); check("rel_level3", 32'(lv), 32'hF);
        check("rel_any3", 32'(ae), 1);
        tick(1); check("rel_edge4", 32'(ed), 0); check("rel_sticky4", 32'(es), 32'hF);

        // rise-only channel 0
        reset_n = 1'b0; data = '0; mode = 8'h01; tick(1);
        reset_n = 1'b1; tick(4);
        data = 4'b0001;
        tick(2); check("rise_e2", 32'(ed), 0);
        tick(1); check("rise_e3", 32'(ed), 1); check("rise_lv3", 32'(lv), 1);
        tick(1); check("rise_e4", 32'(ed), 0);
        data = '0;
        tick(3); check("rise_fall_lv", 32'(lv), 0); check("rise_fall_nopulse", 32'(ed), 0);
        clear = '1; tick(1); clear = '0;

        // debounce on channel 1
        mode = 8'h0C; db_limit = 3;
        data = 4'b0010; tick(2); data = '0; tick(10);
        check("glitch_lv", 32'(lv), 0); check("glitch_sticky", 32'(es), 0);
        data = 4'b0010;
        tick(5); check("db_rise_e5", 32'(ed), 0);
        clear = 4'b0010;
        tick(1); check("db_rise_e6", 32'(ed), 32'h2); check("db_rise_lv", 32'(lv), 32'h2);
        check("sticky_set_wins", 32'(es), 32'h2);
        clear = '0;
        tick(20); check("sticky_hold", 32'(es), 32'h2);
        clear = 4'b0010; tick(1); clear = '0;
        check("sticky_cleared", 32'(es), 0);
        data = '0;
        tick(5); check("db_fall_e5", 32'(ed), 0);
        tick(1); check("db_fall_e6", 32'(ed), 32'h2); check("db_fall_lv", 32'(lv), 0);

        // mixed modes {both, fall, rise, off}
        mode = 8'hE4; db_limit = 0; tick(6);
        clear = '1; tick(1); clear = '0;
        data = 4'hF;
        tick(2); check("mix_r_e2", 32'(ed), 0);
        tick(1); check("mix_r_e3", 32'(ed), 32'hA); check("mix_r_any", 32'(ae), 1);
        check("mix_r_lv", 32'(lv), 32'hF);
        tick(1); check("mix_r_e4", 32'(ed), 0); check("mix_r_any4", 32'(ae), 0);
        data = '0;
        tick(3); check("mix_f_e3", 32'(ed), 32'hC); check("mix_f_lv", 32'(lv), 0);

        // reset in the middle of a debounce count
        mode = 8'hFF; db_limit = 5; tick(10);
        data = 4'b0100; tick(5);
        reset_n = 1'b0; tick(1);
        check("mid_rst_lv", 32'(lv), 0); check("mid_rst_sticky", 32'(es), 0);
        reset_n = 1'b1;
        tick(7); check("mid_rst_e7", 32'(ed), 0);
        tick(1); check("mid_rst_e8", 32'(ed), 32'h4); check("mid_rst_lv8", 32'(lv), 32'h4);

        // random stimulus against the model
        for (int c = 0; c < 2000; c++) begin
            reset_n = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < int'(WIDTH); i++) begin
                if ($urandom_range(0, 7) == 0) data[i] = ~data[i];
                clear[i] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 99) == 0) mode = 8'($urandom);
            if ($urandom_range(0, 149) == 0) db_limit = 4'($urandom_range(0, 3));
            tick(1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
Parametrised, multi-channel successor to the single-bit edge_detector. Each channel synchronises an asynchronous input, debounces it against a programmable stability threshold, and detects edges per a runtime-selectable mode (off/rise/fall/both). It produces a one-cycle pulse, a sticky status bit with clear, and a filtered level per channel. It sits between raw external pins (buttons, interrupt lines) and control FSMs or status registers.

Parameters:
WIDTH, 4, number of independent channels
SYNC_STAGES, 2, synchroniser flops per channel (min 2)
DB_W, 4, width of debounce counter and db_limit

Ports:
clock  in  1  single clock, all flops rising-edge
reset_n  in  1  synchronous, active-low reset
data  in  WIDTH  asynchronous raw inputs
mode  in  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
db_limit  in  DB_W  stable cycles required beyond first; 0 = no filtering; shared by all channels
clear  in  WIDTH  per-channel sticky clear, level-sensitive
edge_detect  out  WIDTH  one-cycle pulse per qualified edge
edge_sticky  out  WIDTH  latched edge_detect, held until cleared
level  out  WIDTH  debounced level
any_edge  out  1  OR-reduce of edge_detect, registered in same cycle as edge_detect

Behaviour:
- Reset: sampled on clock edge with reset_n=0; clears sync chain, counters, level, edge_detect, edge_sticky, any_edge to 0. No async path.
- Sync: data[i] through SYNC_STAGES flops; sync[i] = last stage.
- Debounce per channel, each edge: if sync==level then cnt<=0; else if cnt>=db_limit then level<=sync, cnt<=0, change event; else cnt<=cnt+1 (cannot overflow, since it stops at db_limit).
- Latency: with data stable, level and edge_detect update at clock edge SYNC_STAGES+1+db_limit, counting the first edge that samples new data as edge 1.
- Glitch rejection: a pulse at sync shorter than db_limit+1 cycles produces no level change and no pulse; cnt restarts at 0.
- Edge qualify: on a change event, edge_detect[i]<=1 if (new level=1 and mode[i] in {rise,both}) or (new level=0 and mode[i] in {fall,both}); otherwise 0. Pulse is exactly one cycle; back-to-back events give separate pulses.
- mode=off: level still tracks; no pulse, no sticky set. Mode changes take effect at the next edge and never disturb cnt/level.
- db_limit changed mid-count: compare uses current value (>=). If cnt already >= new limit, level updates at the next edge.
- Sticky: edge_sticky[i] <= (edge_sticky[i] & ~clear[i]) | edge_pulse_next[i]. Set wins over simultaneous clear.
- After reset release with data high, level=0 initially, so a rise event is reported after normal latency. This is intended behaviour.
- Channels are fully independent; simultaneous events on all channels are all reported.

Decomposition:
- Package edge_pkg: mode constants EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11; default SYNC_STAGES and DB_W.
- Sub-module edge_channel: one channel with sync, debounce counter, qualify and sticky. The top instantiates WIDTH copies via generate and ORs them into any_edge.

Test Plan:
- Reset: reset_n=0 for 3 cycles with data=4'hF, mode=8'hFF -> all outputs 0; release -> rise pulses on all channels at edge 3 (db_limit=0).
- Rise only: db_limit=0, ch0 mode=01, data[0] 0->1 -> edge_detect[0]=1 for exactly one cycle at edge 3, level[0]=1 same cycle; data[0] 1->0 -> level[0]=0 at edge 3, no pulse.
- Debounce: ch1 mode=11, db_limit=3; data[1] high 2 cycles -> no pulse, level[1]=0; data[1] high 10 cycles -> pulse at edge 6, falling pulse 6 edges after drop.
- Sticky: after ch0 pulse, edge_sticky[0] stays 1 for 20 cycles; clear[0]=1 one cycle -> 0 next edge; clear[0] asserted in pulse cycle -> edge_sticky[0] remains 1.
- Mixed modes: mode={11,10,01,00} (ch3..ch0), db_limit=0; data 0->F -> pulses ch1, ch3; F->0 -> pulses ch2, ch3; ch0 never pulses but level[0] toggles; any_edge=1 only in pulse cycles.
- Reset mid-debounce: db_limit=5, data[2] high, reset_n=0 at cnt=3 -> cnt and level cleared; after release with data[2] still high -> pulse at full latency of 8 edges.
